// File: rtl/cmlk_3d_ddr_burst_writer.sv
// Drains the packed-image FWFT FIFO into DDR as fixed-length AXI4 INCR write bursts, ping-ponging frames
// between two buffers. Optional statistics counters are built when CMLK_3D_BURST_WR_STAT_EN is defined.
//
// state | meaning
// IDLE  | wait for enable and a full burst in the FIFO; apply soft clear
// ADDR  | awvalid high until the address handshake
// DATA  | stream BURST_LEN beats straight from the FIFO head
// RESP  | accept the write response, advance the frame position
module cmlk_3d_ddr_burst_writer #(
  parameter int BURST_LEN   = 16,
  parameter int FRAME_WORDS = 524288,
  parameter int CNT_W       = 11
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             init_txn,
  input  logic             wr2ddr_en,
  input  logic [31:0]      buf_base0,
  input  logic [31:0]      buf_base1,
  input  logic [31:0]      fifo_rddata,
  input  logic [CNT_W-1:0] fifo_rd_count,
  output logic             fifo_rden,
  output logic [31:0]      m_axi_awaddr,
  output logic [7:0]       m_axi_awlen,
  output logic [2:0]       m_axi_awsize,
  output logic [1:0]       m_axi_awburst,
  output logic             m_axi_awvalid,
  input  logic             m_axi_awready,
  output logic [31:0]      m_axi_wdata,
  output logic [3:0]       m_axi_wstrb,
  output logic             m_axi_wlast,
  output logic             m_axi_wvalid,
  input  logic             m_axi_wready,
  input  logic [1:0]       m_axi_bresp,
  input  logic             m_axi_bvalid,
  output logic             m_axi_bready,
  output logic             frame_done,
  output logic             buf_idx,
  output logic             wr_err
`ifdef CMLK_3D_BURST_WR_STAT_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int WC_W = $clog2(FRAME_WORDS) + 1;
  localparam logic [7:0]      LAST_BEAT = 8'(BURST_LEN - 1);
  localparam logic [WC_W-1:0] BL_WC     = WC_W'(BURST_LEN);
  localparam logic [WC_W-1:0] FW_WC     = WC_W'(FRAME_WORDS);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t            state_q, state_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              wlast_q, wlast_d;
  logic              bready_q, bready_d;
  logic [7:0]        beat_q, beat_d;
  logic [WC_W-1:0]   word_cnt_q, word_cnt_d;
  logic [WC_W-1:0]   word_sum;
  logic              buf_idx_q, buf_idx_d;
  logic              wr_err_q, wr_err_d;
  logic              frame_done_q, frame_done_d;
  logic              clr_pend_q, clr_pend_d;
`ifdef CMLK_3D_BURST_WR_STAT_EN
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [31:0]       stall_cnt_q, stall_cnt_d;
`endif

  always_comb begin
    state_d      = state_q;
    awaddr_d     = awaddr_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    wlast_d      = wlast_q;
    bready_d     = bready_q;
    beat_d       = beat_q;
    word_cnt_d   = word_cnt_q;
    buf_idx_d    = buf_idx_q;
    wr_err_d     = wr_err_q;
    frame_done_d = 1'b0;
    clr_pend_d   = clr_pend_q;
    word_sum     = word_cnt_q + BL_WC;

    case (state_q)
      IDLE: begin
        clr_pend_d = 1'b0;
        if (init_txn) begin
          word_cnt_d = '0;
          buf_idx_d  = 1'b0;
          wr_err_d   = 1'b0;
        end else if (wr2ddr_en && (32'(fifo_rd_count) >= 32'(BURST_LEN))) begin
          state_d   = ADDR;
          awvalid_d = 1'b1;
          awaddr_d  = (buf_idx_q ? buf_base1 : buf_base0) + (32'(word_cnt_q) << 2);
        end
      end
      ADDR: begin
        if (init_txn) clr_pend_d = 1'b1;
        if (m_axi_awready) begin
          state_d   = DATA;
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wlast_d   = 1'b0;
          beat_d    = '0;
        end
      end
      DATA: begin
        if (init_txn) clr_pend_d = 1'b1;
        if (m_axi_wready) begin
          if (wlast_q) begin
            state_d  = RESP;
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
          end else begin
            beat_d  = beat_q + 8'd1;
            wlast_d = ((beat_q + 8'd1) == LAST_BEAT);
          end
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          state_d  = IDLE;
          bready_d = 1'b0;
          // A clear requested mid-burst wins over the frame position and suppresses frame_done.
          if (clr_pend_q || init_txn) begin
            word_cnt_d = '0;
            buf_idx_d  = 1'b0;
            wr_err_d   = 1'b0;
            clr_pend_d = 1'b0;
          end else begin
            wr_err_d = wr_err_q | (m_axi_bresp != 2'b00);
            if (word_sum == FW_WC) begin
              word_cnt_d   = '0;
              buf_idx_d    = ~buf_idx_q;
              frame_done_d = 1'b1;
            end else begin
              word_cnt_d = word_sum;
            end
          end
        end else if (init_txn) begin
          clr_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CMLK_3D_BURST_WR_STAT_EN
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (init_txn) begin
      frame_cnt_d = '0;
      stall_cnt_d = '0;
    end else begin
      if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
      if ((state_q == ADDR && !m_axi_awready) || (state_q == DATA && !m_axi_wready))
        stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      awaddr_q     <= '0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      wlast_q      <= 1'b0;
      bready_q     <= 1'b0;
      beat_q       <= '0;
      word_cnt_q   <= '0;
      buf_idx_q    <= 1'b0;
      wr_err_q     <= 1'b0;
      frame_done_q <= 1'b0;
      clr_pend_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      awaddr_q     <= awaddr_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      wlast_q      <= wlast_d;
      bready_q     <= bready_d;
      beat_q       <= beat_d;
      word_cnt_q   <= word_cnt_d;
      buf_idx_q    <= buf_idx_d;
      wr_err_q     <= wr_err_d;
      frame_done_q <= frame_done_d;
      clr_pend_q   <= clr_pend_d;
    end
  end

  assign fifo_rden     = wvalid_q & m_axi_wready;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = LAST_BEAT;
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = fifo_rddata;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = wlast_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;
  assign frame_done    = frame_done_q;
  assign buf_idx       = buf_idx_q;
  assign wr_err        = wr_err_q;

endmodule
